fb_swap_controller: RTL and testbench
=====================================

# fb_swap_controller

Double-buffer controller between the column transformer and the two frame-buffer BRAMs. It routes the transformer's pixel writes into the back buffer and holds the frame's last pixel until the display's next new-frame pulse. It then swaps front and back buffers and acknowledges the transformer with `frame_buff_ready_out`. It also polices write addresses and counts frames the renderer failed to finish in time.

## Interface
- `SCREEN_WIDTH`, default 320: render width in pixels.
- `SCREEN_HEIGHT`, default 180: render height in pixels.
- `FB_PIXELS`, default SCREEN_WIDTH*SCREEN_HEIGHT (57600): valid address range is 0..FB_PIXELS-1.
- `pixel_clk_in`, in, 1: the only clock.
- `rst_in`, in, 1: synchronous reset, active-low.
- `ray_valid_in`, in, 1: `ray_address_in`/`ray_pixel_in` are valid this cycle.
- `ray_address_in`, in, 16: linear pixel address, hcount + vcount*SCREEN_WIDTH.
- `ray_pixel_in`, in, 16: RGB565 pixel.
- `ray_last_pixel_in`, in, 1: with valid, marks the final pixel of a frame. The transformer holds it until it sees ready.
- `new_frame_in`, in, 1: one-cycle pulse from the display timing at the start of vertical blank.
- `frame_buff_ready_out`, out, 1: one-cycle acknowledge that the swap is complete.
- `wr_en_out`, out, 2: one-hot BRAM write enable. Bit i targets buffer i.
- `wr_addr_out`, out, 16: BRAM write address.
- `wr_data_out`, out, 16: BRAM write data.
- `front_sel_out`, out, 1: buffer index the display reads.
- `late_frame_count_out`, out, 8: saturating count of new-frame pulses that arrived before the frame was complete.
- `addr_err_out`, out, 1: sticky flag, set when an out-of-range write was dropped.

## Operation
- The back buffer is always `~front_sel_out`.
- States:
  - RENDER:
    - Each cycle with `ray_valid_in` and `ray_address_in < FB_PIXELS`, issue a write to the back buffer.
    - If the address is out of range, suppress the write and set `addr_err_out`.
    - On valid & last, write the pixel (same range check) and go to WAIT_VBLANK.
  - WAIT_VBLANK:
    - All `ray_*` inputs are ignored. The held last pixel is not rewritten.
    - On `new_frame_in`, go to SWAP.
  - SWAP:
    - Lasts exactly one cycle.
    - `front_sel_out` toggles.
    - `frame_buff_ready_out` = 1.
    - Next state is RENDER.
- Late frame: `new_frame_in` while in RENDER means no swap happens. The display re-shows the old front buffer, and `late_frame_count_out` increments, saturating at 255.
- Simultaneous valid & last & `new_frame_in` in RENDER: write the last pixel and go directly to SWAP. This is not counted as late.
- `new_frame_in` during SWAP is ignored. It is not counted as late.
- `ray_valid_in` without last during WAIT_VBLANK is a protocol violation. Drop it; it is not flagged.
- Address compare is unsigned 16-bit. `wr_addr_out` passes the input address through unmodified.

## Timing
- Reset (`rst_in` = 0 at a clock edge) sets:
  - state = RENDER
  - `front_sel_out` = 0
  - `wr_en_out` = 2'b00
  - `wr_addr_out` = 0
  - `wr_data_out` = 0
  - `frame_buff_ready_out` = 0
  - `late_frame_count_out` = 0
  - `addr_err_out` = 0
- Reset mid-operation discards any pending swap. The transformer must itself be reset in the same cycle.
- Write path: all write outputs are registered. A pixel accepted at edge t drives `wr_en_out`/`wr_addr_out`/`wr_data_out` during cycle t+1. `wr_en_out` is 2'b00 in every other cycle.
- Swap path: `new_frame_in` sampled in WAIT_VBLANK at edge t gives SWAP during cycle t+1. In that cycle `front_sel_out` is already toggled and `frame_buff_ready_out` = 1. The block is back in RENDER at cycle t+2.
- `frame_buff_ready_out` is never high for more than one consecutive cycle.
- The `addr_err_out` and `late_frame_count_out` updates are visible one cycle after the triggering event.

## Structure
- Shared package `raycaster_pkg` holds:
  - the `t_fb_state` enum {RENDER, WAIT_VBLANK, SWAP};
  - the SCREEN_WIDTH/SCREEN_HEIGHT/FB_PIXELS localparams;
  - the RGB565 colour constants used by the transformer.
- There is no sub-module. The BRAMs and the display-side read mux live in the top level and are driven by `front_sel_out`.
- The 8-bit saturating counter is inline logic.

## Test plan
- Reset: hold `rst_in` = 0 for 3 cycles, then release. Every output is at its reset value, and `wr_en_out` stays 2'b00 while no input is valid.
- Normal frame, starting with `front_sel_out` = 0:
  - valid at address 0x0005 with data 0x7670 gives `wr_en_out` = 2'b10, `wr_addr_out` = 5, `wr_data_out` = 0x7670 one cycle later.
  - Last pixel at address 57599, held high, is written exactly once.
  - `new_frame_in` 10 cycles later gives `front_sel_out` = 1 and a single-cycle `frame_buff_ready_out` pulse one cycle later.
- Late frame: `new_frame_in` in RENDER before last. `late_frame_count_out` goes 0 to 1, `front_sel_out` is unchanged, and there is no ready pulse. 256 further late pulses leave the count at 255.
- Coincident events: valid & last & `new_frame_in` in one RENDER cycle. The write occurs, the swap occurs, ready pulses at t+1, and `late_frame_count_out` stays 0.
- Out-of-range address: write to address 57600 gives no `wr_en_out`, `addr_err_out` = 1, and the flag stays set through later valid writes until reset.
- Reset mid-operation: assert `rst_in` = 0 while in WAIT_VBLANK, release, then pulse `new_frame_in`. There is no swap, `front_sel_out` = 0, and there is no ready pulse.

Source files
------------

// File: rtl/raycaster_pkg.sv
// Shared raycaster types and constants: frame-buffer controller states,
// render geometry and the RGB565 palette used by the column transformer.
package raycaster_pkg;

  typedef enum logic [1:0] {
    RENDER      = 2'd0,
    WAIT_VBLANK = 2'd1,
    SWAP        = 2'd2
  } t_fb_state;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 180;
  localparam int FB_PIXELS     = SCREEN_WIDTH * SCREEN_HEIGHT;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;
  localparam logic [15:0] RGB565_GREY  = 16'h7BEF;

endpackage

// File: rtl/fb_swap_controller.sv
// Double-buffer controller: steers transformer writes into the back buffer,
// swaps buffers on the display's new-frame pulse once a frame is complete.
module fb_swap_controller
  import raycaster_pkg::*;
#(
  parameter int SCREEN_WIDTH  = raycaster_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = raycaster_pkg::SCREEN_HEIGHT,
  parameter int FB_PIXELS     = SCREEN_WIDTH * SCREEN_HEIGHT
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        ray_valid_in,
  input  logic [15:0] ray_address_in,
  input  logic [15:0] ray_pixel_in,
  input  logic        ray_last_pixel_in,
  input  logic        new_frame_in,
  output logic        frame_buff_ready_out,
  output logic [1:0]  wr_en_out,
  output logic [15:0] wr_addr_out,
  output logic [15:0] wr_data_out,
  output logic        front_sel_out,
  output logic [7:0]  late_frame_count_out,
  output logic        addr_err_out
);

  // 17 bits so a full 64K buffer still compares correctly
  localparam logic [16:0] FB_LIMIT = 17'(FB_PIXELS);

  t_fb_state   state_reg, state_next;
  logic        front_sel_reg, front_sel_next;
  logic [1:0]  wr_en_reg, wr_en_next;
  logic [15:0] wr_addr_reg, wr_addr_next;
  logic [15:0] wr_data_reg, wr_data_next;
  logic [7:0]  late_cnt_reg, late_cnt_next;
  logic        addr_err_reg, addr_err_next;

  logic accept;
  logic in_range;
  logic last_accept;

  assign accept      = (state_reg == RENDER) && ray_valid_in;
  assign in_range    = ({1'b0, ray_address_in} < FB_LIMIT);
  assign last_accept = accept && ray_last_pixel_in;

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      state_reg <= RENDER;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RENDER: begin
        if (last_accept) begin
          state_next = new_frame_in ? SWAP : WAIT_VBLANK;
        end
      end
      WAIT_VBLANK: begin
        if (new_frame_in) begin
          state_next = SWAP;
        end
      end
      SWAP:    state_next = RENDER;
      default: state_next = RENDER;
    endcase
  end

  always_comb begin
    frame_buff_ready_out = (state_reg == SWAP);
    front_sel_next       = front_sel_reg ^ (state_next == SWAP && state_reg != SWAP);
    wr_en_next           = 2'b00;
    wr_addr_next         = wr_addr_reg;
    wr_data_next         = wr_data_reg;
    addr_err_next        = addr_err_reg;
    late_cnt_next        = late_cnt_reg;
    if (accept) begin
      if (in_range) begin
        // back buffer is the one the display is not reading
        wr_en_next   = front_sel_reg ? 2'b01 : 2'b10;
        wr_addr_next = ray_address_in;
        wr_data_next = ray_pixel_in;
      end else begin
        addr_err_next = 1'b1;
      end
    end
    if (state_reg == RENDER && new_frame_in && !last_accept && late_cnt_reg != 8'hFF) begin
      late_cnt_next = late_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      front_sel_reg <= 1'b0;
      wr_en_reg     <= 2'b00;
      wr_addr_reg   <= 16'd0;
      wr_data_reg   <= 16'd0;
      late_cnt_reg  <= 8'd0;
      addr_err_reg  <= 1'b0;
    end else begin
      front_sel_reg <= front_sel_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      late_cnt_reg  <= late_cnt_next;
      addr_err_reg  <= addr_err_next;
    end
  end

  assign front_sel_out        = front_sel_reg;
  assign wr_en_out            = wr_en_reg;
  assign wr_addr_out          = wr_addr_reg;
  assign wr_data_out          = wr_data_reg;
  assign late_frame_count_out = late_cnt_reg;
  assign addr_err_out         = addr_err_reg;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed bench for fb_swap_controller: reset, normal swap, late frames,
// coincident last/new-frame, address policing and mid-frame reset.
module tb_fb_swap_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ray_valid;
  logic [15:0] ray_address;
  logic [15:0] ray_pixel;
  logic        ray_last;
  logic        new_frame;
  logic        ready;
  logic [1:0]  wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        front_sel;
  logic [7:0]  late_count;
  logic        addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fb_swap_controller dut (
    .pixel_clk_in        (clk),
    .rst_in              (rst_n),
    .ray_valid_in        (ray_valid),
    .ray_address_in      (ray_address),
    .ray_pixel_in        (ray_pixel),
    .ray_last_pixel_in   (ray_last),
    .new_frame_in        (new_frame),
    .frame_buff_ready_out(ready),
    .wr_en_out           (wr_en),
    .wr_addr_out         (wr_addr),
    .wr_data_out         (wr_data),
    .front_sel_out       (front_sel),
    .late_frame_count_out(late_count),
    .addr_err_out        (addr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                       input logic l, input logic nf);
    ray_valid   = v;
    ray_address = a;
    ray_pixel   = d;
    ray_last    = l;
    new_frame   = nf;
  endtask

  initial begin
    int writes;
    int readies;

    rst_n = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (3) step();
    check("rst_front_sel", 32'(front_sel), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_late", 32'(late_count), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_wr_en", 32'(wr_en), 32'd0);

    // normal frame into back buffer 1
    drive(1'b1, 16'h0005, 16'h7670, 1'b0, 1'b0);
    step();
    check("wr0_en", 32'(wr_en), 32'd2);
    check("wr0_addr", 32'(wr_addr), 32'd5);
    check("wr0_data", 32'(wr_data), 32'h7670);
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    step();
    check("wr0_en_drop", 32'(wr_en), 32'd0);

    drive(1'b1, 16'd57599, 16'h1234, 1'b1, 1'b0);
    step();
    check("last_en", 32'(wr_en), 32'd2);
    check("last_addr", 32'(wr_addr), 32'd57599);
    check("last_data", 32'(wr_data), 32'h1234);
    writes = 0;
    readies = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_en != 2'b00) writes++;
      if (ready) readies++;
    end
    check("last_held_rewrites", 32'(writes), 32'd0);
    check("wait_no_ready", 32'(readies), 32'd0);
    check("wait_front_sel", 32'(front_sel), 32'd0);
    new_frame = 1'b1;
    step();
    check("swap_front_sel", 32'(front_sel), 32'd1);
    check("swap_ready", 32'(ready), 32'd1);
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    step();
    check("swap_ready_1cyc", 32'(ready), 32'd0);
    check("swap_front_hold", 32'(front_sel), 32'd1);

    // back buffer is now 0
    drive(1'b1, 16'h0007, 16'hF800, 1'b0, 1'b0);
    step();
    check("wr1_en", 32'(wr_en), 32'd1);
    check("wr1_addr", 32'(wr_addr), 32'd7);
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);

    // late frames
    new_frame = 1'b1;
    step();
    check("late_first", 32'(late_count), 32'd1);
    check("late_front_sel", 32'(front_sel), 32'd1);
    check("late_ready", 32'(ready), 32'd0);
    readies = 0;
    for (int i = 0; i < 256; i++) begin
      new_frame = 1'b0;
      step();
      new_frame = 1'b1;
      step();
      if (ready) readies++;
    end
    new_frame = 1'b0;
    step();
    check("late_saturate", 32'(late_count), 32'd255);
    check("late_loop_ready", 32'(readies), 32'd0);

    // coincident last + new_frame from fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b1, 16'd100, 16'hABCD, 1'b1, 1'b1);
    step();
    check("coin_wr_en", 32'(wr_en), 32'd2);
    check("coin_wr_addr", 32'(wr_addr), 32'd100);
    check("coin_front_sel", 32'(front_sel), 32'd1);
    check("coin_ready", 32'(ready), 32'd1);
    check("coin_late", 32'(late_count), 32'd0);
    new_frame = 1'b1;
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    step();
    check("coin_swap_nf_ignored", 32'(late_count), 32'd0);
    check("coin_ready_1cyc", 32'(ready), 32'd0);
    check("coin_front_hold", 32'(front_sel), 32'd1);
    new_frame = 1'b0;

    // out-of-range addresses
    drive(1'b1, 16'd57600, 16'h0001, 1'b0, 1'b0);
    step();
    check("oor_wr_en", 32'(wr_en), 32'd0);
    check("oor_err", 32'(addr_err), 32'd1);
    drive(1'b1, 16'd3, 16'h0002, 1'b0, 1'b0);
    step();
    check("oor_after_wr_en", 32'(wr_en), 32'd1);
    check("oor_err_sticky", 32'(addr_err), 32'd1);
    drive(1'b1, 16'hFFFF, 16'h0003, 1'b0, 1'b0);
    step();
    check("oor_ffff_wr_en", 32'(wr_en), 32'd0);

    // protocol violation in WAIT_VBLANK, then mid-operation reset
    drive(1'b1, 16'd10, 16'h0004, 1'b1, 1'b0);
    step();
    check("wait_last_en", 32'(wr_en), 32'd1);
    drive(1'b1, 16'd20, 16'h0005, 1'b0, 1'b0);
    step();
    check("wait_valid_dropped", 32'(wr_en), 32'd0);
    check("wait_err_unflagged", 32'(addr_err), 32'd1);
    rst_n = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    check("mid_rst_err", 32'(addr_err), 32'd0);
    step();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    check("mid_rst_front_sel", 32'(front_sel), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_late", 32'(late_count), 32'd1);
    step();
    check("mid_rst_ready_after", 32'(ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
